// File: rtl/imm_gen_pipe.sv
// Immediate generator with a one-deep skid buffer: decodes RV immediates and, with
// IMM_GEN_TGT_EN defined, the branch/jump target pc_in + imm; otherwise out_tgt is 0.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_in,
    input  logic [2:0]      imm_sel,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_tgt,
    output logic            out_illegal
);

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_I    = 3'b001;
    localparam logic [2:0] SEL_S    = 3'b010;
    localparam logic [2:0] SEL_B    = 3'b011;
    localparam logic [2:0] SEL_U    = 3'b100;
    localparam logic [2:0] SEL_J    = 3'b101;
    localparam logic [2:0] SEL_CSR  = 3'b110;
    localparam logic [2:0] SEL_ILL  = 3'b111;

    // Each format is gathered into a signed field of its natural width, so the
    // size cast to XLEN performs the sign extension.
    function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] instr,
                                                          input logic [2:0]  sel);
        logic signed [XLEN-1:0] imm;
        logic signed [11:0]     i12;
        logic signed [11:0]     s12;
        logic signed [12:0]     b13;
        logic signed [31:0]     u32;
        logic signed [20:0]     j21;
        i12 = instr[31:20];
        s12 = {instr[31:25], instr[11:7]};
        b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        u32 = {instr[31:12], 12'b0};
        j21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm = '0;
        case (sel)
            SEL_NONE: imm = '0;
            SEL_I:    imm = XLEN'(i12);
            SEL_S:    imm = XLEN'(s12);
            SEL_B:    imm = XLEN'(b13);
            SEL_U:    imm = XLEN'(u32);
            SEL_J:    imm = XLEN'(j21);
            SEL_CSR:  imm = $signed(XLEN'(instr[19:15]));
            SEL_ILL:  imm = '0;
            default:  imm = '0;
        endcase
        return imm;
    endfunction

    // ---- stage p0: combinational decode of the offered instruction ----
    logic signed [XLEN-1:0] imm_p0;
    logic                   ill_p0;
    logic                   in_xfer;
    logic                   load_out;

    assign imm_p0   = decode_imm(instr_in, imm_sel);
    assign ill_p0   = (imm_sel == SEL_ILL);
    assign in_xfer  = in_valid && in_ready;

    // ---- stage p1: main output register plus skid register ----
    logic                   vld_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic                   ill_p1;
    logic                   vld_skid;
    logic signed [XLEN-1:0] imm_skid;
    logic                   ill_skid;

    // OUT may take new data when it is empty or being drained this cycle.
    assign load_out = !vld_p1 || out_ready;

`ifdef IMM_GEN_TGT_EN
    logic [XLEN-1:0] tgt_p0;
    logic [XLEN-1:0] tgt_p1;
    logic [XLEN-1:0] tgt_skid;

    assign tgt_p0 = pc_in + $unsigned(imm_p0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            vld_skid <= 1'b0;
            imm_p1   <= '0;
            ill_p1   <= 1'b0;
`ifdef IMM_GEN_TGT_EN
            tgt_p1   <= '0;
`endif
        end else if (load_out) begin
            if (vld_skid) begin
                vld_p1   <= 1'b1;
                imm_p1   <= imm_skid;
                ill_p1   <= ill_skid;
`ifdef IMM_GEN_TGT_EN
                tgt_p1   <= tgt_skid;
`endif
                vld_skid <= 1'b0;
            end else if (in_xfer) begin
                vld_p1   <= 1'b1;
                imm_p1   <= imm_p0;
                ill_p1   <= ill_p0;
`ifdef IMM_GEN_TGT_EN
                tgt_p1   <= tgt_p0;
`endif
            end else begin
                vld_p1   <= 1'b0;
            end
        end else if (in_xfer) begin
            vld_skid <= 1'b1;
            imm_skid <= imm_p0;
            ill_skid <= ill_p0;
`ifdef IMM_GEN_TGT_EN
            tgt_skid <= tgt_p0;
`endif
        end
    end

    assign in_ready    = !vld_skid;
    assign out_valid   = vld_p1;
    assign out_imm     = imm_p1;
    assign out_illegal = ill_p1;

`ifdef IMM_GEN_TGT_EN
    assign out_tgt = tgt_p1;
    logic unused_opcode;
    assign unused_opcode = ^instr_in[6:0];
`else
    assign out_tgt = '0;
    logic unused_inputs;
    assign unused_inputs = ^{instr_in[6:0], pc_in};
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against an arithmetic reference model of the RV immediate formats.
module tb_imm_gen_pipe;

`ifdef IMM_GEN_TGT_EN
    localparam bit TGT = 1'b1;
`else
    localparam bit TGT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [63:0] pc64;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tgt32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64, tgt64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .instr_in(instr), .imm_sel(sel), .pc_in(pc64[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(imm32), .out_tgt(tgt32), .out_illegal(ill32));

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr_in(instr), .imm_sel(sel), .pc_in(pc64),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(imm64), .out_tgt(tgt64), .out_illegal(ill64));

    typedef struct {
        bit [31:0] imm32;
        bit [31:0] tgt32;
        bit [63:0] imm64;
        bit [63:0] tgt64;
        bit        ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Immediate value as a plain integer, built from the field weights of each format.
    function automatic longint model_imm(input bit [31:0] ins, input bit [2:0] s);
        longint v;
        case (s)
            3'd1: v = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd2: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7])
                      - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd3: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd4: v = longint'(ins[31:12]) * 4096 - (ins[31] ? (64'sd1 <<< 32) : 64'sd0);
            3'd5: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - (ins[31] ? (64'sd1 <<< 20) : 64'sd0);
            3'd6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic exp_t model(input bit [31:0] ins, input bit [2:0] s, input bit [63:0] pc);
        exp_t   e;
        longint v;
        bit [63:0] u;
        v       = model_imm(ins, s);
        u       = v;
        e.imm64 = u;
        e.imm32 = u[31:0];
        e.ill   = (s == 3'd7);
        e.tgt64 = TGT ? pc + u : 64'd0;
        e.tgt32 = TGT ? pc[31:0] + u[31:0] : 32'd0;
        return e;
    endfunction

    // Stimulus side: record every accepted instruction.
    always @(negedge clk) begin
        if (rst) q.delete();
        else if (in_valid && in_ready32) q.push_back(model(instr, sel, pc64));
    end

    // Monitor: compare each delivered payload and check stall stability.
    bit        held = 1'b0;
    bit [31:0] held_imm32;
    bit [63:0] held_imm64;
    always @(negedge clk) begin
        exp_t e;
        if (held) begin
            check("hold_valid", out_valid32, 1'b1);
            check("hold_imm32", imm32, held_imm32);
            check("hold_imm64", imm64, held_imm64);
        end
        held = 1'b0;
        if (!rst && out_valid32 && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got imm %h expected no output", imm32);
            end else begin
                e = q.pop_front();
                check("imm32", imm32, e.imm32);
                check("tgt32", tgt32, e.tgt32);
                check("ill32", ill32, e.ill);
                check("imm64", imm64, e.imm64);
                check("tgt64", tgt64, e.tgt64);
                check("ill64", ill64, e.ill);
            end
        end else if (!rst && out_valid32 && !out_ready) begin
            held       = 1'b1;
            held_imm32 = imm32;
            held_imm64 = imm64;
        end
    end

    // Occupancy: SKID is full exactly when two accepted items are undelivered.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("in_ready32", in_ready32, q.size() < 2);
            check("in_ready64", in_ready64, q.size() < 2);
            check("out_valid32", out_valid32, q.size() != 0);
            check("out_valid64", out_valid64, q.size() != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit [31:0] ins, input bit [2:0] s, input bit [63:0] pc,
                        input bit [63:0] e_imm64, input bit [63:0] e_tgt64, input bit e_ill);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = ins;
        sel       = s;
        pc64      = pc;
        tick();
        in_valid  = 1'b0;
        check("dir_valid", out_valid32, 1'b1);
        check("dir_imm32", imm32, e_imm64[31:0]);
        check("dir_imm64", imm64, e_imm64);
        check("dir_tgt32", tgt32, TGT ? e_tgt64[31:0] : 32'd0);
        check("dir_tgt64", tgt64, TGT ? e_tgt64 : 64'd0);
        check("dir_ill", ill32, e_ill);
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; sel = '0; pc64 = '0;
        repeat (3) tick();
        check("rst_out_valid", out_valid32, 1'b0);
        check("rst_in_ready", in_ready32, 1'b1);
        check("rst_imm", imm32, 32'd0);
        check("rst_tgt", tgt64, 64'd0);
        check("rst_ill", ill64, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        beat(32'hFFF00093, 3'b001, 64'h0,   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        beat(32'hFE000EE3, 3'b011, 64'h200, 64'hFFFFFFFFFFFFFFFC, 64'h1FC, 1'b0);
        beat(32'h800000B7, 3'b100, 64'h0,   64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0);
        beat(32'h0080006F, 3'b101, 64'h100, 64'h8, 64'h108, 1'b0);
        beat(32'hFFFFFFFF, 3'b111, 64'h40,  64'h0, 64'h40, 1'b1);
        beat(32'h000F8073, 3'b110, 64'h0,   64'h1F, 64'h1F, 1'b0);

        // Backpressure: A then B while the consumer stalls.
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 3'b001; pc64 = 64'h0;
        instr = 32'h00500093;
        tick();
        instr = 32'h00700093;
        tick();
        in_valid = 1'b0;
        check("bp_in_ready", in_ready32, 1'b0);
        check("bp_head", imm32, 32'd5);
        out_ready = 1'b1;
        tick();
        check("bp_second", imm32, 32'd7);
        check("bp_second_valid", out_valid32, 1'b1);
        tick();
        check("bp_drained", out_valid32, 1'b0);

        // Reset with OUT and SKID both full; an offer during reset must be ignored.
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00100093;
        tick();
        instr = 32'h00200093;
        tick();
        rst = 1'b1;
        instr = 32'h00300093;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_valid", out_valid32, 1'b0);
        check("mid_rst_ready", in_ready32, 1'b1);
        check("mid_rst_imm", imm32, 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("mid_rst_no_stale", out_valid64, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = $urandom;
            sel       = 3'($urandom_range(0, 7));
            pc64      = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        check("drain_empty", q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32; legal values 32 and 64; sets the immediate and target datapath width.
REQ-002 SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, an instruction is offered this cycle.
REQ-005 SHALL have port in_ready, output, 1, the block can accept an offer this cycle.
REQ-006 SHALL have port instr_in, input, 32, raw instruction word.
REQ-007 SHALL have port imm_sel, input, 3, immediate format: 000 NONE, 001 I, 010 S, 011 B, 100 U, 101 J, 110 CSR (zimm), 111 illegal.
REQ-008 SHALL have port pc_in, input, XLEN, PC of the offered instruction.
REQ-009 SHALL have port out_valid, output, 1, the output payload is valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts the payload.
REQ-011 SHALL have port out_imm, output, XLEN, decoded immediate.
REQ-012 SHALL have port out_tgt, output, XLEN, pc_in + out_imm.
REQ-013 SHALL have port out_illegal, output, 1, imm_sel was 111.

Function
REQ-014 SHALL decode I/S/B/J exactly per the RV base encodings; sign bit is instr_in[31], sign-extended to XLEN; B and J have bit 0 = 0.
REQ-015 SHALL form U as {instr_in[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-016 SHALL form CSR as instr_in[19:15] zero-extended to XLEN.
REQ-017 SHALL drive out_imm to 0 for NONE and for illegal (111); illegal SHALL also set out_illegal=1.
REQ-018 SHALL count an input transfer when in_valid and in_ready are both 1, and an output transfer when out_valid and out_ready are both 1.
REQ-019 SHALL hold a main output register (OUT) plus one skid register (SKID), each with its own valid bit; in_ready SHALL equal the inverse of SKID valid, from a register.
REQ-020 SHALL reload OUT when OUT is empty or an output transfer occurs: from SKID if SKID is valid (SKID then empties); otherwise from the input if an input transfer occurs; otherwise OUT goes invalid.
REQ-021 SHALL write SKID when OUT is valid, out_ready=0, and an input transfer occurs.
REQ-022 SHALL have latency of 1 cycle: a payload accepted in cycle N appears on the outputs in cycle N+1 when OUT was empty or drained in cycle N.
REQ-023 SHALL sustain 1 transfer per cycle with out_ready held at 1, and SHALL preserve order across all stall patterns.
REQ-024 SHALL hold OUT payload and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL compute out_tgt as a modulo 2^XLEN sum with no overflow flag.

Reset
REQ-026 SHALL clear OUT valid and SKID valid on a cycle with rst=1, drive in_ready=1 and out_valid=0 in the following cycle, and set out_imm, out_tgt and out_illegal to 0.
REQ-027 SHALL discard in-flight payloads on reset mid-operation, and SHALL not register any input transfer during a reset cycle.

Configuration
REQ-028 SHALL include the pc_in + imm adder and drive out_tgt when macro IMM_GEN_TGT_EN is defined.
REQ-029 SHALL keep pc_in on the port list but ignore it, omit the adder and SKID target storage, and tie out_tgt to 0 when IMM_GEN_TGT_EN is undefined.

Verification
REQ-030 SHALL cover XLEN=32: instr 0xFFF00093, sel 001 -> out_imm 0xFFFFFFFF one cycle after acceptance.
REQ-031 SHALL cover the B format: instr 0xFE000EE3, sel 011, pc 0x200 -> out_imm 0xFFFFFFFC, out_tgt 0x1FC (TGT_EN defined).
REQ-032 SHALL cover XLEN=64: instr 0x800000B7, sel 100 -> out_imm 0xFFFFFFFF80000000; instr 0x0080006F, sel 101, pc 0x100 -> out_tgt 0x108.
REQ-033 SHALL cover backpressure: out_ready=0 while pushing A then B -> in_ready drops the cycle after B is accepted; release -> A then B on consecutive cycles, no loss or duplication.
REQ-034 SHALL cover the illegal selector: sel 111 -> out_illegal=1 and out_imm 0.
REQ-035 SHALL cover reset mid-operation: rst=1 with OUT and SKID full -> out_valid=0 and in_ready=1 the next cycle, and no stale payload is emitted afterwards.
